// File: rtl/serial_addsub_flags_pkg.sv
// Shared definitions for the bit-serial add/subtract engine: FSM encoding and
// overflow-event counter constants.
package serial_addsub_flags_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int              OVF_CNT_W = 4;
    localparam logic [OVF_CNT_W-1:0] OVF_CNT_SAT = 4'hF;

endpackage

// File: rtl/serial_addsub_flags_fa_bit.sv
// One-bit full adder used as the serial bit cell for both the add and the
// subtract path.
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub_flags.sv
// Bit-serial A+B / A-B engine, LSB first, one bit per clock, with carry and
// signed-overflow flags and a saturating overflow-event counter.
module serial_addsub_flags
    import serial_addsub_flags_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     sum,
    output logic [WIDTH-1:0]     diff,
    output logic                 add_co,
    output logic                 add_cy,
    output logic                 sub_co,
    output logic                 sub_cy,
    output logic [OVF_CNT_W-1:0] ovf_cnt,
    output state_e               dbg_state
);

    localparam int               BW       = $clog2(WIDTH);
    localparam logic [BW-1:0]    BIT_LAST = BW'(WIDTH - 1);

    state_e                 state_q;
    logic [BW-1:0]          bitcnt_q;
    logic [WIDTH-1:0]       a_sh_q, b_sh_q, sum_sh_q, diff_sh_q;
    logic                   c_add_q, c_sub_q;
    logic                   add_cmsb_q, sub_cmsb_q;
    logic                   busy_q, done_q;
    logic [WIDTH-1:0]       sum_q, diff_q;
    logic                   add_co_q, add_cy_q, sub_co_q, sub_cy_q;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q;

    logic add_s_d, add_c_d, sub_s_d, sub_c_d;
    logic add_ovf_d, sub_ovf_d;

    fa_bit u_fa_add (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .cin_i  (c_add_q),
        .s_o    (add_s_d),
        .cout_o (add_c_d)
    );

    // Subtraction as A + ~B + 1: the +1 comes from presetting the sub carry.
    fa_bit u_fa_sub (
        .a_i    (a_sh_q[0]),
        .b_i    (~b_sh_q[0]),
        .cin_i  (c_sub_q),
        .s_o    (sub_s_d),
        .cout_o (sub_c_d)
    );

    assign add_ovf_d = c_add_q ^ add_cmsb_q;
    assign sub_ovf_d = c_sub_q ^ sub_cmsb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            diff_sh_q  <= '0;
            c_add_q    <= 1'b0;
            c_sub_q    <= 1'b0;
            add_cmsb_q <= 1'b0;
            sub_cmsb_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            diff_q     <= '0;
            add_co_q   <= 1'b0;
            add_cy_q   <= 1'b0;
            sub_co_q   <= 1'b0;
            sub_cy_q   <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        c_add_q  <= 1'b0;
                        c_sub_q  <= 1'b1;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    sum_sh_q  <= {add_s_d, sum_sh_q[WIDTH-1:1]};
                    diff_sh_q <= {sub_s_d, diff_sh_q[WIDTH-1:1]};
                    c_add_q   <= add_c_d;
                    c_sub_q   <= sub_c_d;
                    bitcnt_q  <= bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        // Carry into the MSB cell, needed for signed overflow.
                        add_cmsb_q <= c_add_q;
                        sub_cmsb_q <= c_sub_q;
                        busy_q     <= 1'b0;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q   <= 1'b1;
                    sum_q    <= sum_sh_q;
                    diff_q   <= diff_sh_q;
                    add_co_q <= c_add_q;
                    add_cy_q <= add_ovf_d;
                    sub_co_q <= c_sub_q;
                    sub_cy_q <= sub_ovf_d;
                    if ((add_ovf_d | sub_ovf_d) && (ovf_cnt_q != OVF_CNT_SAT)) begin
                        ovf_cnt_q <= ovf_cnt_q + 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            // Placed last so a clear beats a same-edge increment.
            if (clr_cnt) begin
                ovf_cnt_q <= '0;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign diff      = diff_q;
    assign add_co    = add_co_q;
    assign add_cy    = add_cy_q;
    assign sub_co    = sub_co_q;
    assign sub_cy    = sub_cy_q;
    assign ovf_cnt   = ovf_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub_flags.sv
// Directed-vector bench for serial_addsub_flags (WIDTH=4) with an expected-result
// queue drained by a monitor on every done pulse.
module tb_serial_addsub_flags;
    import serial_addsub_flags_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       clr_cnt = 1'b0;
    logic       busy, done, add_co, add_cy, sub_co, sub_cy;
    logic [3:0] sum, diff, ovf_cnt;
    state_e     dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [3:0] model_cnt = '0;

    // {sum, diff, add_co, add_cy, sub_co, sub_cy, ovf_cnt}
    logic [15:0] exp_q[$];

    serial_addsub_flags #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .clr_cnt   (clr_cnt),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .diff      (diff),
        .add_co    (add_co),
        .add_cy    (add_cy),
        .sub_co    (sub_co),
        .sub_cy    (sub_cy),
        .ovf_cnt   (ovf_cnt),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard
    task automatic push_exp(input logic [3:0] s, input logic [3:0] d, input logic aco,
                            input logic acy, input logic sco, input logic scy, input logic clr);
        if (clr) model_cnt = '0;
        else if ((acy | scy) && model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
        exp_q.push_back({s, d, aco, acy, sco, scy, model_cnt});
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no expected result (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("sum",     32'(sum),     32'(e[15:12]));
                check("diff",    32'(diff),    32'(e[11:8]));
                check("add_co",  32'(add_co),  32'(e[7]));
                check("add_cy",  32'(add_cy),  32'(e[6]));
                check("sub_co",  32'(sub_co),  32'(e[5]));
                check("sub_cy",  32'(sub_cy),  32'(e[4]));
                check("ovf_cnt", 32'(ovf_cnt), 32'(e[3:0]));
            end
        end
    end

    // driver
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [3:0] av, input logic [3:0] bv);
        int lat;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        check("busy_in_run", 32'(busy), 32'd1);
        wait_done(lat);
        check("latency", 32'(lat), 32'd5);
    endtask

    initial begin
        int lat;
        int prev_cyc;

        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, sum, diff, add_co, add_cy, sub_co, sub_cy, ovf_cnt}, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1-4: directed vectors
        push_exp(4'h8, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op(4'h7, 4'h1);
        push_exp(4'h7, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(4'h2, 4'h5);
        push_exp(4'h0, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(4'hF, 4'h1);
        push_exp(4'h9, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op(4'h8, 4'h1);

        // 5: 17 back-to-back overflowing ops with start held high
        for (int i = 0; i < 17; i++) push_exp(4'h8, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        a = 4'h7;
        b = 4'h1;
        start = 1'b1;
        prev_cyc = 0;
        for (int i = 0; i < 17; i++) begin
            wait_done(lat);
            if (lat < 0) begin
                check("b2b_done_timeout", 32'd0, 32'd1);
                break;
            end
            if (i > 0) check("b2b_interval", 32'(cyc - prev_cyc), 32'd6);
            prev_cyc = cyc;
        end
        start = 1'b0;
        @(negedge clk);
        check("cnt_saturated", 32'(ovf_cnt), 32'hF);

        // clear on the same edge as an increment
        push_exp(4'h8, 4'h6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        a = 4'h7;
        b = 4'h1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        check("clr_latency_done", 32'(done), 32'd1);
        clr_cnt = 1'b0;

        // raise the counter again so the reset test clears something non-zero
        push_exp(4'h9, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_op(4'h8, 4'h1);

        // 6: reset two cycles into RUN
        @(negedge clk);
        a = 4'h7;
        b = 4'h1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_outputs", {busy, done, sum, diff, add_co, add_cy, sub_co, sub_cy, ovf_cnt}, 32'd0);
        check("midrun_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_cnt = '0;
        repeat (10) @(negedge clk);

        push_exp(4'h7, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(4'h2, 4'h5);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
